// File: rtl/trng_uart_pkg.sv
// Shared types and constants for the TRNG UART receive path.
package trng_uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/trng_rx_fifo.sv
// Small synchronous FIFO holding received bytes; extra pointer MSB tells full from empty.
module trng_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trng_uart_rx.sv
// UART 8N1 receiver for the TRNG serial stream: synchroniser, bit FSM and byte FIFO.
module trng_uart_rx
  import trng_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic                      rx_serial,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overrun,
  output logic                      o_busy
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]   LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_nxt;
  logic                      rx_meta;
  logic                      rx_s;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      cnt_clr;
  logic                      shift_en;
  logic                      push;
  logic                      frame_err_nxt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;

  // Both flops reset high so a line held low through reset still looks like a fresh start edge.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_clr       = 1'b0;
    shift_en      = 1'b0;
    push          = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == IDLE)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
      o_frame_err <= frame_err_nxt;
      o_overrun   <= push && fifo_full && !pop;
    end
  end

  assign pop     = o_valid && i_ready;
  assign o_valid = !fifo_empty;
  assign o_busy  = (state != IDLE);

  trng_rx_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_sys),
    .rst      (rst),
    .push     (push),
    .push_data(shift),
    .pop      (pop),
    .head     (o_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
